// File: rtl/mul_acc_seq.sv
// Sequential multiply-accumulate: radix-2 shift-add multiplier feeding a
// persistent accumulator. Each transaction takes WIDTH+3 cycles with no
// backpressure. Valid/ready handshakes are used on both the input and the
// output side.
module mul_acc_seq #(
    parameter int WIDTH     = 8,
    parameter int ACC_WIDTH = 2*WIDTH+8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic                 in_signed,
    input  logic                 in_acc,
    input  logic                 acc_clear,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] out_result,
    output logic                 out_ovf
);
    localparam int PW = 2*WIDTH;
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, MUL, ACC, DONE} state_t;

    state_t                 state_q, state_d;
    logic [PW-1:0]          mcand_q, mcand_d;
    logic [WIDTH-1:0]       mplier_q, mplier_d;
    logic [PW-1:0]          partial_q, partial_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   sgn_q, sgn_d;
    logic                   accm_q, accm_d;
    logic                   neg_q, neg_d;
    logic [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic                   ovf_q, ovf_d;

    logic [WIDTH-1:0]       mag_a, mag_b;
    logic [PW-1:0]          prod;
    logic [ACC_WIDTH-1:0]   prod_ext;
    logic [ACC_WIDTH:0]     sum;
    logic                   add_ovf;

    // Operand magnitudes; -2^(WIDTH-1) maps to 2^(WIDTH-1), which still fits unsigned.
    always_comb begin
        mag_a = (in_signed && in_a[WIDTH-1]) ? -in_a : in_a;
        mag_b = (in_signed && in_b[WIDTH-1]) ? -in_b : in_b;
    end

    // Signed product from magnitude and sign, extended to the accumulator width, plus the add and its overflow.
    always_comb begin
        prod                = neg_q ? -partial_q : partial_q;
        prod_ext            = {ACC_WIDTH{sgn_q & prod[PW-1]}};
        prod_ext[PW-1:0]    = prod;
        sum                 = {1'b0, acc_q} + {1'b0, prod_ext};
        if (sgn_q)
            add_ovf = (acc_q[ACC_WIDTH-1] == prod_ext[ACC_WIDTH-1]) &&
                      (sum[ACC_WIDTH-1] != acc_q[ACC_WIDTH-1]);
        else
            add_ovf = sum[ACC_WIDTH];
    end

    // FSM next-state and datapath next-state.
    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        partial_d = partial_q;
        cnt_d     = cnt_q;
        sgn_d     = sgn_q;
        accm_d    = accm_q;
        neg_d     = neg_q;
        acc_d     = acc_q;
        ovf_d     = ovf_q;
        unique case (state_q)
            IDLE: begin
                // Clear happens first so that a same-cycle accept accumulates onto zero.
                if (acc_clear) begin
                    acc_d = '0;
                    ovf_d = 1'b0;
                end
                if (in_valid) begin
                    sgn_d     = in_signed;
                    accm_d    = in_acc;
                    mcand_d   = PW'(mag_a);
                    mplier_d  = mag_b;
                    neg_d     = in_signed & (in_a[WIDTH-1] ^ in_b[WIDTH-1]);
                    partial_d = '0;
                    cnt_d     = '0;
                    state_d   = MUL;
                end
            end
            MUL: begin
                if (mplier_q[0])
                    partial_d = partial_q + mcand_q;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH-1))
                    state_d = ACC;
            end
            ACC: begin
                // A product always fits in ACC_WIDTH, so replace mode never overflows.
                acc_d   = accm_q ? sum[ACC_WIDTH-1:0] : prod_ext;
                ovf_d   = accm_q & add_ovf;
                state_d = DONE;
            end
            DONE: begin
                if (out_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register; reset discards any in-flight transaction.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            mcand_q   <= '0;
            mplier_q  <= '0;
            partial_q <= '0;
            cnt_q     <= '0;
            sgn_q     <= 1'b0;
            accm_q    <= 1'b0;
            neg_q     <= 1'b0;
            acc_q     <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            partial_q <= partial_d;
            cnt_q     <= cnt_d;
            sgn_q     <= sgn_d;
            accm_q    <= accm_d;
            neg_q     <= neg_d;
            acc_q     <= acc_d;
            ovf_q     <= ovf_d;
        end
    end

    // Outputs are state decodes or registers; in_ready is also held low during reset.
    always_comb begin
        in_ready   = (state_q == IDLE) && !reset;
        out_valid  = (state_q == DONE);
        out_result = acc_q;
        out_ovf    = ovf_q;
    end
endmodule

// File: tb/tb_mul_acc_seq.sv
// Directed bench for mul_acc_seq. Two instances (ACC_WIDTH 24 and 16) share
// every input, so the 16-bit one exercises the overflow cases while the
// 24-bit one checks exact results.
module tb_mul_acc_seq;
    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_signed, in_acc, acc_clear, out_ready;
    logic [7:0]  in_a, in_b;
    logic        rdy24, rdy16, v24, v16, ovf24, ovf16;
    logic [23:0] res24;
    logic [15:0] res16;

    int nchk = 0;
    int nerr = 0;

    logic [23:0] r24;
    logic [15:0] r16;
    logic        o24, o16;
    int          lat;

    always #5 clk = ~clk;

    mul_acc_seq #(.WIDTH(8), .ACC_WIDTH(24)) dut24 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy24),
        .in_a(in_a), .in_b(in_b), .in_signed(in_signed), .in_acc(in_acc),
        .acc_clear(acc_clear), .out_valid(v24), .out_ready(out_ready),
        .out_result(res24), .out_ovf(ovf24)
    );

    mul_acc_seq #(.WIDTH(8), .ACC_WIDTH(16)) dut16 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy16),
        .in_a(in_a), .in_b(in_b), .in_signed(in_signed), .in_acc(in_acc),
        .acc_clear(acc_clear), .out_valid(v16), .out_ready(out_ready),
        .out_result(res16), .out_ovf(ovf16)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called #1 after an edge while both DUTs are in IDLE; returns in cycle 1.
    task automatic start(input logic [7:0] a, input logic [7:0] b,
                         input logic s, input logic ac, input logic clr);
        in_valid  = 1'b1;
        in_a      = a;
        in_b      = b;
        in_signed = s;
        in_acc    = ac;
        acc_clear = clr;
        step();
        in_valid  = 1'b0;
        acc_clear = 1'b0;
    endtask

    // Counts cycles from accept until out_valid, bounded.
    task automatic wait_done(output int n);
        n = 1;
        while (!(v24 && v16) && n < 100) begin
            step();
            n++;
        end
    endtask

    // Full transaction with out_ready=1: checks latency, captures results, checks return to IDLE.
    task automatic txn(input logic [7:0] a, input logic [7:0] b,
                       input logic s, input logic ac, input logic clr);
        start(a, b, s, ac, clr);
        check("busy_rdy", 32'(rdy24), 32'd0);
        wait_done(lat);
        check("lat", 32'(lat), 32'd10);
        r24 = res24;
        r16 = res16;
        o24 = ovf24;
        o16 = ovf16;
        step();
        check("rdy_ret", 32'({rdy24, rdy16, v24}), 32'b110);
    endtask

    logic [23:0] hold_r;
    logic        hold_o;
    logic        seen;
    logic [23:0] exp200 [3] = '{24'h009C40, 24'h013880, 24'h01D4C0};

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0;
        in_signed = 1'b0; in_acc = 1'b0; acc_clear = 1'b0; out_ready = 1'b1;
        step();
        step();
        check("rst_rdy", 32'({rdy24, rdy16}), 32'd0);
        check("rst_out", 32'({v24, ovf24, res24}), 32'd0);
        reset = 1'b0;
        #1;
        check("rdy_after_rst", 32'({rdy24, rdy16}), 32'b11);
        step();

        // Unsigned replace 255*255
        txn(8'd255, 8'd255, 1'b0, 1'b0, 1'b0);
        check("u_rep24", 32'(r24), 32'h00FE01);
        check("u_rep_ovf", 32'(o24), 32'd0);
        check("u_rep16", 32'(r16), 32'hFE01);

        // Unsigned accumulate: wraps in 16 bits
        txn(8'd255, 8'd255, 1'b0, 1'b1, 1'b0);
        check("u_acc16", 32'(r16), 32'hFC02);
        check("u_ovf16", 32'(o16), 32'd1);
        check("u_acc24", 32'({o24, r24}), 32'h01FC02);

        // Signed replace
        txn(8'h80, 8'h80, 1'b1, 1'b0, 1'b0);
        check("s_minmin", 32'(r24), 32'h004000);
        txn(8'hFD, 8'h05, 1'b1, 1'b0, 1'b0);
        check("s_neg", 32'(r24), 32'hFFFFF1);
        check("s_neg_ovf", 32'(o24), 32'd0);

        // Signed overflow in 16 bits
        txn(8'h7F, 8'h7F, 1'b1, 1'b0, 1'b0);
        check("s_rep16", 32'(r16), 32'h3F01);
        txn(8'h7F, 8'h7F, 1'b1, 1'b1, 1'b0);
        check("s_acc16_a", 32'({o16, r16}), 32'h07E02);
        txn(8'h7F, 8'h7F, 1'b1, 1'b1, 1'b0);
        check("s_acc16_b", 32'(r16), 32'hBD03);
        check("s_ovf16", 32'(o16), 32'd1);

        // Standalone clear in IDLE clears result and overflow
        acc_clear = 1'b1;
        step();
        acc_clear = 1'b0;
        check("clr", 32'({ovf16, res24}), 32'd0);
        for (int i = 0; i < 3; i++) begin
            txn(8'd200, 8'd200, 1'b0, 1'b1, 1'b0);
            check($sformatf("acc200_%0d", i), 32'(r24), 32'(exp200[i]));
        end

        // Clear in the accept cycle
        txn(8'd2, 8'd3, 1'b0, 1'b1, 1'b1);
        check("clr_accept", 32'(r24), 32'h000006);

        // Zero operand
        txn(8'd0, 8'd200, 1'b0, 1'b0, 1'b0);
        check("zero", 32'(r24), 32'd0);

        // Backpressure: DONE ignores inputs and holds outputs
        out_ready = 1'b0;
        start(8'd10, 8'd10, 1'b0, 1'b0, 1'b0);
        wait_done(lat);
        check("bp_lat", 32'(lat), 32'd10);
        hold_r = res24;
        hold_o = ovf24;
        check("bp_res", 32'(hold_r), 32'd100);
        for (int i = 0; i < 5; i++) begin
            in_valid  = i[0];
            in_a      = 8'(i * 37);
            acc_clear = ~i[0];
            step();
            check("bp_hold", 32'({v24, rdy24, ovf24, res24}),
                  32'({1'b1, 1'b0, hold_o, hold_r}));
        end
        in_valid  = 1'b0;
        acc_clear = 1'b0;
        out_ready = 1'b1;
        step();
        check("bp_release", 32'({rdy24, v24, res24}), 32'({2'b10, 24'd100}));

        // Reset in MUL cycle 4 on a nonzero accumulator
        start(8'd7, 8'd9, 1'b0, 1'b1, 1'b0);
        step();
        step();
        step();
        reset = 1'b1;
        #1;
        check("midrst_rdy", 32'(rdy24), 32'd0);
        step();
        reset = 1'b0;
        #1;
        check("midrst_out", 32'({v24, ovf24, res24, ovf16}), 32'd0);
        check("midrst_rdy1", 32'(rdy24), 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            step();
            seen = seen | v24 | v16;
        end
        check("no_ghost", 32'(seen), 32'd0);
        txn(8'd2, 8'd2, 1'b0, 1'b1, 1'b0);
        check("post_rst", 32'(r24), 32'h000004);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule
